// File: rtl/events_rate_sequencer.sv
// Sequences an event-rate block: clears it, waits for its interval flag, reads
// and latches every channel count, then streams the counts out one word per
// handshake. It also keeps a frame counter and sticky overrun/timeout flags.
//
// Ports:
//   clk, reset_n      - rising-edge clock, async active-low reset
//   run               - level request for continuous acquisition
//   err_clear         - pulse, clears sticky overrun/timeout
//   rate_clear/read   - one-cycle strobes to the event-rate block
//   rate_ready        - interval-elapsed flag from the event-rate block
//   rate_count        - packed per-channel counts, channel i at [i*CL +: CL]
//   out_valid/ready   - stream handshake; out_data/out_channel/out_last payload
//   frame_id          - completed-frame counter (wraps at 2^16)
//   busy/overrun/timeout - status, sticky error flags
module events_rate_sequencer #(
    parameter int unsigned CHANNEL_NUMBER = 2,
    parameter int unsigned COUNTER_LENGTH = 24,
    parameter int unsigned TIMEOUT_CYCLES = 10000000
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      run,
    input  logic                                      err_clear,
    output logic                                      rate_clear,
    output logic                                      rate_read,
    input  logic                                      rate_ready,
    input  logic [CHANNEL_NUMBER*COUNTER_LENGTH-1:0]  rate_count,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [COUNTER_LENGTH-1:0]                 out_data,
    output logic [((CHANNEL_NUMBER > 1) ? $clog2(CHANNEL_NUMBER) : 1)-1:0] out_channel,
    output logic                                      out_last,
    output logic [15:0]                               frame_id,
    output logic                                      busy,
    output logic                                      overrun,
    output logic                                      timeout
);

    localparam int unsigned CH_W    = (CHANNEL_NUMBER > 1) ? $clog2(CHANNEL_NUMBER) : 1;
    localparam int unsigned DWELL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CH_W-1:0]    LAST_IDX  = CH_W'(CHANNEL_NUMBER - 1);
    localparam logic [DWELL_W-1:0] DWELL_END = DWELL_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd4;
    localparam logic [2:0] S_SEND  = 3'd5;

    logic [2:0]                state_q, state_d;
    logic [DWELL_W-1:0]        dwell_q, dwell_d;
    logic [CH_W-1:0]           idx_q, idx_d;
    logic [COUNTER_LENGTH-1:0] buf_q [CHANNEL_NUMBER];
    logic [COUNTER_LENGTH-1:0] buf_d [CHANNEL_NUMBER];

    logic                      rate_clear_q, rate_clear_d;
    logic                      rate_read_q, rate_read_d;
    logic                      out_valid_q, out_valid_d;
    logic [COUNTER_LENGTH-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]           out_channel_q, out_channel_d;
    logic                      out_last_q, out_last_d;
    logic [15:0]               frame_id_q, frame_id_d;
    logic                      busy_q, busy_d;
    logic                      overrun_q, overrun_d;
    logic                      timeout_q, timeout_d;

    logic                      timeout_set;
    logic                      overrun_set;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        dwell_d     = '0;
        idx_d       = idx_q;
        frame_id_d  = frame_id_q;
        timeout_set = 1'b0;
        overrun_set = 1'b0;
        for (int i = 0; i < int'(CHANNEL_NUMBER); i++) begin
            buf_d[i] = buf_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = run ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                // Dropping run wins over both ready and timeout: no strobe follows.
                if (!run) begin
                    state_d = S_IDLE;
                end else if (rate_ready) begin
                    state_d = S_READ;
                end else if (dwell_q == DWELL_END) begin
                    timeout_set = 1'b1;
                    state_d     = S_CLEAR;
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            S_READ: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                // Counts are valid here: the event-rate block registers them
                // one cycle after it sees rate_read.
                for (int i = 0; i < int'(CHANNEL_NUMBER); i++) begin
                    buf_d[i] = rate_count[i*COUNTER_LENGTH +: COUNTER_LENGTH];
                end
                idx_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                overrun_set = rate_ready;
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        frame_id_d = frame_id_q + 16'd1;
                        state_d    = run ? S_WAIT : S_IDLE;
                    end else begin
                        idx_d = idx_q + CH_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Sticky flags: a new set condition beats err_clear.
        overrun_d = overrun_set | (overrun_q & ~err_clear);
        timeout_d = timeout_set | (timeout_q & ~err_clear);

        // Outputs are registered images of the next state.
        rate_clear_d  = (state_d == S_CLEAR);
        rate_read_d   = (state_d == S_READ);
        busy_d        = (state_d != S_IDLE);
        out_valid_d   = (state_d == S_SEND);
        out_last_d    = out_valid_d && (idx_d == LAST_IDX);
        out_channel_d = out_valid_d ? idx_d : out_channel_q;
        out_data_d    = out_valid_d ? buf_d[idx_d] : out_data_q;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            dwell_q       <= '0;
            idx_q         <= '0;
            for (int i = 0; i < int'(CHANNEL_NUMBER); i++) begin
                buf_q[i] <= '0;
            end
            rate_clear_q  <= 1'b0;
            rate_read_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
            out_last_q    <= 1'b0;
            frame_id_q    <= '0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            dwell_q       <= dwell_d;
            idx_q         <= idx_d;
            for (int i = 0; i < int'(CHANNEL_NUMBER); i++) begin
                buf_q[i] <= buf_d[i];
            end
            rate_clear_q  <= rate_clear_d;
            rate_read_q   <= rate_read_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            out_last_q    <= out_last_d;
            frame_id_q    <= frame_id_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
        end
    end

    assign rate_clear  = rate_clear_q;
    assign rate_read   = rate_read_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;
    assign out_last    = out_last_q;
    assign frame_id    = frame_id_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_events_rate_sequencer.sv
// Directed bench for events_rate_sequencer: a small event-rate block model,
// a word scoreboard and a negedge monitor for strobes and stream stability.
module tb_events_rate_sequencer;

    localparam int unsigned CN = 2;
    localparam int unsigned CL = 24;
    localparam int unsigned TO = 50;

    typedef struct packed {
        logic [0:0]  ch;
        logic [23:0] data;
        logic        last;
    } word_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic            run = 1'b0;
    logic            err_clear = 1'b0;
    logic            rate_clear;
    logic            rate_read;
    logic            rate_ready = 1'b0;
    logic [CN*CL-1:0] rate_count = '1;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [CL-1:0]   out_data;
    logic [0:0]      out_channel;
    logic            out_last;
    logic [15:0]     frame_id;
    logic            busy;
    logic            overrun;
    logic            timeout;

    logic [CN*CL-1:0] next_counts = '0;
    word_t            sb[$];

    int tests = 0;
    int fails = 0;

    // Monitor bookkeeping (written only by the monitor).
    int    cyc = 0;
    int    clear_cnt = 0, clear_hi = 0, read_cnt = 0, read_hi = 0;
    int    last_clear_cyc = 0, prev_clear_cyc = 0;
    int    last_xfer_cyc = 0, xfer_gap = 0, vis1 = 0;
    logic  prev_clear = 1'b0, prev_read = 1'b0, hold_prev = 1'b0;
    word_t prev_word;

    always #5 clk = ~clk;

    events_rate_sequencer #(
        .CHANNEL_NUMBER(CN),
        .COUNTER_LENGTH(CL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .run(run),
        .err_clear(err_clear),
        .rate_clear(rate_clear),
        .rate_read(rate_read),
        .rate_ready(rate_ready),
        .rate_count(rate_count),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_channel(out_channel),
        .out_last(out_last),
        .frame_id(frame_id),
        .busy(busy),
        .overrun(overrun),
        .timeout(timeout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Event-rate block output register: counts update one edge after rate_read.
    always @(posedge clk) begin
        if (rate_read) rate_count <= next_counts;
    end

    // Monitor: strobe accounting, stream stability and scoreboard pops.
    always @(negedge clk) begin
        word_t w;
        w = '{ch: out_channel, data: out_data, last: out_last};
        cyc++;
        if (rate_clear) begin
            clear_hi++;
            if (!prev_clear) begin
                clear_cnt++;
                prev_clear_cyc = last_clear_cyc;
                last_clear_cyc = cyc;
            end
        end
        if (rate_read) begin
            read_hi++;
            if (!prev_read) read_cnt++;
        end
        prev_clear = rate_clear;
        prev_read  = rate_read;
        if (rate_clear || rate_read) check("strobe_exclusive", 64'(rate_clear && rate_read), 64'd0);
        if (hold_prev && out_valid) check("hold_stable", 64'(w), 64'(prev_word));
        if (out_valid && out_channel == 1'b1) vis1++;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_word", 64'(w), 64'd0);
            end else begin
                check("word", 64'(w), 64'(sb.pop_front()));
            end
            xfer_gap      = cyc - last_xfer_cyc;
            last_xfer_cyc = cyc;
        end
        hold_prev = out_valid && !out_ready;
        prev_word = w;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clear_pulse(input int snap);
        int k;
        k = 0;
        while (clear_cnt == snap && k < 200) begin step(); k++; end
        if (clear_cnt == snap) check("wait_rate_clear_timeout", 64'd0, 64'd1);
    endtask

    // Raise rate_ready and drop it once the read strobe is observed.
    task automatic ready_until_read();
        int snap, k;
        snap = read_cnt;
        k = 0;
        rate_ready = 1'b1;
        while (read_cnt == snap && k < 100) begin step(); k++; end
        rate_ready = 1'b0;
        if (read_cnt == snap) check("wait_rate_read_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!out_valid && k < 20) begin step(); k++; end
        if (!out_valid) check("wait_out_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin step(); k++; end
        check("drain_left", 64'(sb.size()), 64'd0);
    endtask

    task automatic load_frame(input logic [23:0] d0, input logic [23:0] d1);
        next_counts = {d1, d0};
        sb.push_back('{ch: 1'b0, data: d0, last: 1'b0});
        sb.push_back('{ch: 1'b1, data: d1, last: 1'b1});
    endtask

    task automatic start_and_read(input int delay);
        int snap;
        snap = clear_cnt;
        run = 1'b1;
        wait_clear_pulse(snap);
        repeat (delay) step();
        ready_until_read();
    endtask

    task automatic go_idle();
        run = 1'b0;
        repeat (3) step();
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_rate_clear", 64'(rate_clear), 64'd0);
        check("rst_rate_read", 64'(rate_read), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_channel", 64'(out_channel), 64'd0);
        check("rst_frame_id", 64'(frame_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
    endtask

    initial begin
        int s_clr, s_clr_hi, s_rd, s_rd_hi, s_vis;

        // Reset state.
        #2 reset_n = 1'b0;
        #1 check_reset_outputs();
        repeat (2) step();
        reset_n = 1'b1;
        step();

        // Basic frame: one clear, one read, two consecutive words.
        s_clr_hi = clear_hi; s_rd_hi = read_hi;
        load_frame(24'd5, 24'd9);
        start_and_read(20);
        wait_drain();
        check("t1_gap", 64'(xfer_gap), 64'd1);
        check("t1_frame_id", 64'(frame_id), 64'd1);
        check("t1_clear_cycles", 64'(clear_hi - s_clr_hi), 64'd1);
        check("t1_read_cycles", 64'(read_hi - s_rd_hi), 64'd1);
        go_idle();

        // Backpressure on ch1 for 3 cycles.
        out_ready = 1'b0;
        s_vis = vis1;
        load_frame(24'h000011, 24'h000022);
        start_and_read(20);
        wait_valid();
        check("t2_first_channel", 64'(out_channel), 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        step();
        repeat (2) step();
        check("t2_left", 64'(sb.size()), 64'd0);
        check("t2_ch1_visible", 64'(vis1 - s_vis), 64'd4);
        check("t2_frame_id", 64'(frame_id), 64'd2);
        go_idle();

        // Timeout: ready never arrives.
        s_clr = clear_cnt;
        run = 1'b1;
        wait_clear_pulse(s_clr);
        check("t3_timeout_before", 64'(timeout), 64'd0);
        wait_clear_pulse(s_clr + 1);
        check("t3_dwell", 64'(last_clear_cyc - prev_clear_cyc), 64'(TO + 1));
        check("t3_timeout_set", 64'(timeout), 64'd1);
        run = 1'b0;
        step();
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("t3_timeout_cleared", 64'(timeout), 64'd0);
        go_idle();

        // Overrun: ready during a stalled SEND, sticky across the next frame.
        out_ready = 1'b0;
        load_frame(24'h000123, 24'h000456);
        start_and_read(5);
        wait_valid();
        check("t4_overrun_before", 64'(overrun), 64'd0);
        rate_ready = 1'b1;
        step();
        rate_ready = 1'b0;
        check("t4_overrun_set", 64'(overrun), 64'd1);
        out_ready = 1'b1;
        wait_drain();
        load_frame(24'h000077, 24'h000088);
        repeat (5) step();
        ready_until_read();
        wait_drain();
        check("t4_overrun_sticky", 64'(overrun), 64'd1);
        check("t4_frame_id", 64'(frame_id), 64'd4);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("t4_overrun_cleared", 64'(overrun), 64'd0);
        go_idle();

        // run dropped during ch0: frame completes, then idle with no strobes.
        out_ready = 1'b0;
        load_frame(24'h00000a, 24'h00000b);
        start_and_read(5);
        wait_valid();
        run = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        step();
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_frame_id", 64'(frame_id), 64'd5);
        s_clr = clear_cnt; s_rd = read_cnt;
        repeat (10) step();
        check("t5_no_clear", 64'(clear_cnt - s_clr), 64'd0);
        check("t5_no_read", 64'(read_cnt - s_rd), 64'd0);

        // Asynchronous reset mid-SEND.
        out_ready = 1'b0;
        load_frame(24'h000001, 24'h000002);
        start_and_read(5);
        wait_valid();
        #2 reset_n = 1'b0;
        sb.delete();
        #1 check_reset_outputs();
        repeat (2) step();
        s_clr = clear_cnt;
        reset_n = 1'b1;
        wait_clear_pulse(s_clr);
        check("t6_restart_busy", 64'(busy), 64'd1);
        check("t6_restart_valid", 64'(out_valid), 64'd0);
        run = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/events_rate_sequencer.md
EVENTS_RATE_SEQUENCER -- requirements
Module: events_rate_sequencer

Interface
REQ-001 SHALL have parameter CHANNEL_NUMBER, default 2: number of event-rate channels sequenced.
REQ-002 SHALL have parameter COUNTER_LENGTH, default 24: width of each channel count.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 10000000: maximum WAIT_READY dwell, in clk cycles.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port run, input, 1: level; high requests continuous acquisition.
REQ-007 SHALL have port err_clear, input, 1: pulse; clears sticky error flags.
REQ-008 SHALL have port rate_clear, output, 1: clear strobe to the event-rate block.
REQ-009 SHALL have port rate_read, output, 1: read strobe to the event-rate block.
REQ-010 SHALL have port rate_ready, input, 1: interval-elapsed flag from the event-rate block.
REQ-011 SHALL have port rate_count, input, CHANNEL_NUMBER x COUNTER_LENGTH: per-channel counts from the event-rate block.
REQ-012 SHALL have port out_valid, input/ready pair: out_valid output 1, out_ready input 1, stream handshake.
REQ-013 SHALL have port out_data, output, COUNTER_LENGTH: channel count being sent.
REQ-014 SHALL have port out_channel, output, $clog2(CHANNEL_NUMBER) (min 1): channel index of out_data.
REQ-015 SHALL have port out_last, output, 1: high with the last channel of a frame.
REQ-016 SHALL have port frame_id, output, 16: number of completed frames, wraps.
REQ-017 SHALL have ports busy, overrun, timeout, output, 1 each: status, sticky overrun flag, sticky timeout flag.

Function
REQ-018 SHALL implement states IDLE, CLEAR, WAIT_READY, READ, LATCH, SEND.
REQ-019 IDLE: SHALL go to CLEAR when run=1; busy=0 only in IDLE.
REQ-020 CLEAR: SHALL assert rate_clear for exactly one cycle, then go to WAIT_READY.
REQ-021 WAIT_READY: SHALL go to READ on the first cycle rate_ready=1; SHALL count dwell cycles from 0.
REQ-022 WAIT_READY: when the dwell count reaches TIMEOUT_CYCLES with rate_ready=0, SHALL set timeout and go to CLEAR.
REQ-023 READ: SHALL assert rate_read for exactly one cycle, then go to LATCH.
REQ-024 LATCH: SHALL capture all rate_count channels into an internal buffer. This occurs two cycles after the rate_read assertion edge and matches the one-cycle output register of the event-rate block. SHALL then go to SEND with channel index 0.
REQ-025 SEND: SHALL drive out_valid=1, out_data=buffer[idx] and out_channel=idx. Each cycle with out_valid and out_ready both high SHALL transfer one word and increment idx.
REQ-026 While out_valid=1 and out_ready=0, out_data, out_channel and out_last SHALL hold stable.
REQ-027 out_last SHALL be 1 only while idx=CHANNEL_NUMBER-1 in SEND.
REQ-028 When the last word transfers, SHALL increment frame_id by 1, wrapping modulo 2^16.
REQ-029 After the last word transfers, SHALL go to WAIT_READY if run=1, else to IDLE. The READ strobe restarts the event-rate interval, so no CLEAR is issued between frames.
REQ-030 If run falls mid-frame (READ, LATCH or SEND), SHALL complete the current frame before entering IDLE.
REQ-031 If run falls in WAIT_READY or CLEAR, SHALL enter IDLE the next cycle with no strobe issued.
REQ-032 If rate_ready=1 on any SEND cycle, SHALL set overrun: the next interval elapsed before the frame drained.
REQ-033 overrun and timeout SHALL stay set until err_clear=1.
REQ-034 If err_clear coincides with a new set condition, the flag SHALL remain set.
REQ-035 rate_clear and rate_read SHALL never be asserted in the same cycle.
REQ-036 All outputs SHALL be registered.

Reset
REQ-037 On reset_n=0, the block SHALL immediately enter IDLE, independent of clk, and drive:
- rate_clear=0, rate_read=0
- out_valid=0, out_last=0, out_data=0, out_channel=0
- frame_id=0, busy=0, overrun=0, timeout=0
REQ-038 Reset asserted mid-SEND SHALL abandon the frame with no further out_valid; after release, run=1 SHALL restart at CLEAR.

Verification
REQ-039 run=1, rate_ready high 20 cycles after the CLEAR pulse, rate_count={5,9}, out_ready=1 -> exactly one rate_clear pulse, one rate_read pulse, then words (ch0,5) and (ch1,9,last) on consecutive cycles, frame_id=1.
REQ-040 Same stimulus with out_ready low for 3 cycles on ch1 -> ch1 word held stable for 4 cycles, transfers once, no duplicate.
REQ-041 TIMEOUT_CYCLES=50, rate_ready held 0 -> timeout=1 at dwell 50, second rate_clear pulse follows; err_clear -> timeout=0.
REQ-042 rate_ready raised during SEND with out_ready=0 -> overrun=1; it stays 1 through the next frame until err_clear.
REQ-043 run dropped during SEND of ch0 -> ch1 still sent with last, then IDLE, busy=0, no further strobes.
REQ-044 reset_n pulsed low mid-SEND, between clk edges -> outputs at reset values before the next edge, frame_id=0.
